rc4_key_scheduler: RTL and testbench
====================================

# rc4_key_scheduler

RC4 key-scheduling stage (KSA), directly upstream of the RC4 decryptor. Fills the 256-byte S working memory with the identity permutation, then permutes it with the secret key. Shares the S RAM single port with the decryptor through an external mux. Its `done` output drives the decryptor's `start`.

## Interface
Parameters:
- `RAM_WIDTH`, 8, S word width
- `RAM_LENGTH`, 8, S address width (depth 2^RAM_LENGTH = 256)
- `KEY_LENGTH`, 3, key length in bytes

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  level request; acted on at its rising edge only
- `secret_key`  in  8*KEY_LENGTH  key; byte 0 = MSB byte
- `sOut`  in  RAM_WIDTH  S read data, valid one cycle after its address
- `sAddr`  out  RAM_LENGTH  S address
- `sIn`  out  RAM_WIDTH  S write data
- `sWren`  out  1  S write enable
- `busy`  out  1  high from the first INIT cycle until DONE
- `done`  out  1  high in DONE; held until the next start edge or reset

## Operation
- States:
  - IDLE: wait for a start edge.
  - INIT: write S[i]=i, i=0..255, one write per cycle.
  - SH_ADDR: present i on sAddr.
  - SH_READ_SI: capture si=sOut; compute j=j+si+key[kidx]; present the new j on sAddr.
  - SH_READ_SJ: capture sj=sOut.
  - SH_WRITE_I: write sj to address i.
  - SH_WRITE_J: write si to address j; then i++ and kidx++.
  - DONE: wait for a start edge.
- Transitions:
  - IDLE→INIT on a start edge.
  - INIT→SH_ADDR after the i=255 write, with i=0, j=0, kidx=0.
  - SH_WRITE_J→SH_ADDR while i≠255.
  - SH_WRITE_J→DONE after i=255.
  - DONE→INIT on a start edge; i, j, kidx are cleared.
- Arithmetic:
  - i and j are 8-bit and wrap mod 256.
  - kidx is a separate 0..KEY_LENGTH-1 counter that wraps to 0; no divider.
  - key[kidx] = secret_key[8*(KEY_LENGTH-kidx)-1 -: 8].
- Output decode:
  - sWren is decoded combinationally from state: high only in INIT, SH_WRITE_I and SH_WRITE_J.
  - sIn = 0 and sAddr = 0 in every state not listed above.
- `secret_key` is sampled live each SH_READ_SI. It must be held stable while busy.
- A self-swap (i==j) performs both writes with the same value. This is legal.

## Timing
- Start edge: start sampled high at edge E with start low at edge E-1. The first INIT cycle begins at edge E.
- Phase lengths: INIT takes 256 cycles; the shuffle takes 5 cycles per i, 1280 cycles in total.
- `done` rises at edge E+1536. `busy` falls at the same edge.
- A start edge while busy is ignored. start held high never retriggers.
- Reset asserted (low):
  - State goes to IDLE immediately; i, j, kidx, si, sj clear.
  - Outputs: sWren=0, sAddr=0, sIn=0, busy=0, done=0.
  - Applies mid-operation as well. A partially written S is left as is.
- After reset deassertion, one edge is needed to arm the edge detector; start high at that edge is not an edge.

## Configuration
- `RC4_KSA_TAPS_EN` defined: adds debug output ports `iTap`[7:0], `jTap`[7:0], `stateTap`[7:0], driven from the registered i, j and state encoding. Functional behaviour is identical.
- Not defined: these ports and their logic are absent.

## Structure
- Shared package `rc4_pkg` holds:
  - `ksa_state_t` enum (8-bit encoding, usable by the taps)
  - `S_DEPTH`=256
  - the default `KEY_LENGTH`
- One sub-module, `ksa_start_edge`: a registered rising-edge detector with the same async active-low reset.
- The state machine, datapath and output decode live in the top module.

## Test plan
- Reset mid-INIT (reset low at cycle 100) -> sWren=0 in the same cycle; busy=0; no writes until the next start edge.
- start rises, key 24'h000000 -> INIT writes addr n = data n for n=0..255 on consecutive cycles.
- Key 24'h000000, shuffle (RAM model) -> i=0: two writes addr 0 data 0; i=1: addr 1 data 1 twice; i=2: j=3, write S[2]=3 then S[3]=2.
- Key 24'hFF0000 -> i=0: j=8'hFF; write S[0]=8'hFF then S[FF]=8'h00.
- Key 24'h000249, full run -> done exactly 1536 cycles after the start edge; final S matches the software KSA model byte-for-byte.
- Start toggles while busy; second start after done -> no restart while busy; full rerun from INIT after done, with the same cycle count.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: KSA state encoding (8-bit so it can be tapped directly),
// S memory depth and the default key length.
package rc4_pkg;

    localparam int unsigned S_DEPTH            = 256;
    localparam int unsigned DEFAULT_KEY_LENGTH = 3;

    typedef enum logic [7:0] {
        KSA_IDLE       = 8'd0,
        KSA_INIT       = 8'd1,
        KSA_SH_ADDR    = 8'd2,
        KSA_SH_READ_SI = 8'd3,
        KSA_SH_READ_SJ = 8'd4,
        KSA_SH_WRITE_I = 8'd5,
        KSA_SH_WRITE_J = 8'd6,
        KSA_DONE       = 8'd7
    } ksa_state_t;

endpackage

// File: rtl/ksa_start_edge.sv
// Registered rising-edge detector for the KSA start request. The first clock
// after reset only arms the detector, so a start already high then is not an edge.
module ksa_start_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    output logic rise_c_o
);

    logic armed_q;
    logic start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            start_q <= start_i;
        end
    end

    assign rise_c_o = armed_q & start_i & ~start_q;

endmodule

// File: rtl/rc4_key_scheduler.sv
// RC4 key-scheduling stage: identity-fills S, then key-shuffles it over a shared
// single-port RAM. Define RC4_KSA_TAPS_EN to expose iTap/jTap/stateTap debug ports.
module rc4_key_scheduler
    import rc4_pkg::*;
#(
    parameter int unsigned RAM_WIDTH  = 8,
    parameter int unsigned RAM_LENGTH = 8,
    parameter int unsigned KEY_LENGTH = DEFAULT_KEY_LENGTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*KEY_LENGTH-1:0] secret_key,
    input  logic [RAM_WIDTH-1:0]    sOut,
    output logic [RAM_LENGTH-1:0]   sAddr,
    output logic [RAM_WIDTH-1:0]    sIn,
    output logic                    sWren,
    output logic                    busy,
    output logic                    done
`ifdef RC4_KSA_TAPS_EN
    ,
    output logic [7:0]              iTap,
    output logic [7:0]              jTap,
    output logic [7:0]              stateTap
`endif
);

    localparam int unsigned KW = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;
    localparam logic [RAM_LENGTH-1:0] I_LAST    = '1;
    localparam logic [KW-1:0]         KIDX_LAST = KW'(KEY_LENGTH - 1);

    ksa_state_t              state_q, state_d;
    logic [RAM_LENGTH-1:0]   i_q, i_d;
    logic [RAM_LENGTH-1:0]   j_q, j_d;
    logic [KW-1:0]           kidx_q, kidx_d;
    logic [RAM_WIDTH-1:0]    si_q, si_d;
    logic [RAM_WIDTH-1:0]    sj_q, sj_d;
    logic [7:0]              key_byte;
    logic                    start_rise;

    ksa_start_edge u_start_edge (
        .clk      (clk),
        .rst_n    (reset),
        .start_i  (start),
        .rise_c_o (start_rise)
    );

    // Key byte 0 is the most significant byte of secret_key.
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < int'(KEY_LENGTH); k++) begin
            if (kidx_q == KW'(k)) begin
                key_byte = secret_key[8*(int'(KEY_LENGTH)-k)-1 -: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= KSA_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            kidx_q  <= '0;
            si_q    <= '0;
            sj_q    <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            kidx_q  <= kidx_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        si_d    = si_q;
        sj_d    = sj_q;
        sAddr   = '0;
        sIn     = '0;
        sWren   = 1'b0;

        unique case (state_q)
            KSA_IDLE, KSA_DONE: begin
                if (start_rise) begin
                    state_d = KSA_INIT;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                end
            end
            KSA_INIT: begin
                sWren = 1'b1;
                sAddr = i_q;
                sIn   = RAM_WIDTH'(i_q);
                i_d   = i_q + RAM_LENGTH'(1);
                if (i_q == I_LAST) begin
                    state_d = KSA_SH_ADDR;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                end
            end
            KSA_SH_ADDR: begin
                sAddr   = i_q;
                state_d = KSA_SH_READ_SI;
            end
            KSA_SH_READ_SI: begin
                // New j goes straight out so S[j] returns during SH_READ_SJ.
                si_d    = sOut;
                j_d     = j_q + RAM_LENGTH'(sOut) + RAM_LENGTH'(key_byte);
                sAddr   = j_d;
                state_d = KSA_SH_READ_SJ;
            end
            KSA_SH_READ_SJ: begin
                sj_d    = sOut;
                state_d = KSA_SH_WRITE_I;
            end
            KSA_SH_WRITE_I: begin
                sWren   = 1'b1;
                sAddr   = i_q;
                sIn     = sj_q;
                state_d = KSA_SH_WRITE_J;
            end
            KSA_SH_WRITE_J: begin
                sWren   = 1'b1;
                sAddr   = j_q;
                sIn     = si_q;
                i_d     = i_q + RAM_LENGTH'(1);
                kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KW'(1);
                state_d = (i_q == I_LAST) ? KSA_DONE : KSA_SH_ADDR;
            end
            default: begin
                state_d = KSA_IDLE;
            end
        endcase
    end

    assign busy = (state_q != KSA_IDLE) && (state_q != KSA_DONE);
    assign done = (state_q == KSA_DONE);

`ifdef RC4_KSA_TAPS_EN
    assign iTap     = 8'(i_q);
    assign jTap     = 8'(j_q);
    assign stateTap = state_q;
`endif

endmodule

// File: tb/tb_rc4_key_scheduler.sv
// Directed bench for rc4_key_scheduler with a single-port S RAM model, a write log
// and a software KSA reference for final-S comparison.
module tb_rc4_key_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  sOut;
    logic [7:0]  sAddr;
    logic [7:0]  sIn;
    logic        sWren;
    logic        busy;
    logic        done;

    logic [7:0]  mem   [256];
    logic [7:0]  exp_s [256];
    logic [7:0]  wa [$];
    logic [7:0]  wd [$];
    int          wc [$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    rc4_key_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .sOut       (sOut),
        .sAddr      (sAddr),
        .sIn        (sIn),
        .sWren      (sWren),
        .busy       (busy),
        .done       (done)
    );

    // Synchronous RAM (one-cycle read latency) plus a log of every write.
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        sOut <= mem[sAddr];
        if (sWren) begin
            mem[sAddr] <= sIn;
            wa.push_back(sAddr);
            wd.push_back(sIn);
            wc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic ksa_model(input logic [23:0] key);
        logic [7:0] j;
        logic [7:0] t;
        logic [7:0] kb;
        for (int n = 0; n < 256; n++) exp_s[n] = 8'(n);
        j = 8'd0;
        for (int n = 0; n < 256; n++) begin
            kb = 8'(key >> (8 * (2 - (n % 3))));
            j  = j + exp_s[n] + kb;
            t  = exp_s[n];
            exp_s[n] = exp_s[j];
            exp_s[j] = t;
        end
    endtask

    task automatic compare_ram(input string tag);
        int bad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== exp_s[n]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic check_init(input string tag, input int base);
        int bad = 0;
        for (int n = 0; n < 256; n++) begin
            if (wa[base+n] !== 8'(n) || wd[base+n] !== 8'(n) || wc[base+n] != wc[base] + n) bad++;
        end
        check(tag, 32'(bad), 32'd0);
        check({tag, "_count"}, 32'(wa.size() - base), 32'd768);
    endtask

    // Starts at a falling edge, produces a clean start edge, counts cycles to done.
    task automatic run(input logic [23:0] key, input bit toggle, output int cycles, output int base);
        int busy_bad = 0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        secret_key = key;
        base  = wa.size();
        start = 1'b1;
        @(posedge clk);
        cycles = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (!busy) busy_bad++;
            if (toggle && cycles == 300) start = 1'b0;
            if (toggle && cycles == 301) start = 1'b1;
            if (toggle && cycles == 900) start = 1'b0;
            if (toggle && cycles == 905) start = 1'b1;
            if (cycles > 2000) break;
            @(posedge clk);
            cycles++;
        end
        check("busy_while_running", 32'(busy_bad), 32'd0);
        check("busy_at_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int cyc_n;
        int base;
        int n0;

        reset = 1'b0;
        start = 1'b0;
        secret_key = 24'h0;
        repeat (3) @(negedge clk);
        check("rst_sWren", {31'd0, sWren}, 32'd0);
        check("rst_sAddr", 32'(sAddr), 32'd0);
        check("rst_sIn",   32'(sIn),   32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Key 0: INIT sequence, first shuffle steps, cycle count, final S
        run(24'h000000, 1'b0, cyc_n, base);
        check("k0_cycles", 32'(cyc_n), 32'd1536);
        check_init("k0_init", base);
        check("k0_i0_wi", {16'd0, wa[base+256], wd[base+256]}, 32'h0000);
        check("k0_i0_wj", {16'd0, wa[base+257], wd[base+257]}, 32'h0000);
        check("k0_i1_wi", {16'd0, wa[base+258], wd[base+258]}, 32'h0101);
        check("k0_i1_wj", {16'd0, wa[base+259], wd[base+259]}, 32'h0101);
        check("k0_i2_wi", {16'd0, wa[base+260], wd[base+260]}, 32'h0203);
        check("k0_i2_wj", {16'd0, wa[base+261], wd[base+261]}, 32'h0302);
        ksa_model(24'h000000);
        compare_ram("k0_final_s");

        // start held high in DONE must not retrigger
        n0 = wa.size();
        repeat (10) @(negedge clk);
        check("held_done", {31'd0, done}, 32'd1);
        check("held_no_writes", 32'(wa.size() - n0), 32'd0);

        // Key FF0000: first swap uses j = FF
        run(24'hFF0000, 1'b0, cyc_n, base);
        check("kff_cycles", 32'(cyc_n), 32'd1536);
        check("kff_i0_wi", {16'd0, wa[base+256], wd[base+256]}, 32'h00FF);
        check("kff_i0_wj", {16'd0, wa[base+257], wd[base+257]}, 32'hFF00);
        ksa_model(24'hFF0000);
        compare_ram("kff_final_s");

        // Key 000249 with start toggling while busy, then a clean rerun
        run(24'h000249, 1'b1, cyc_n, base);
        check("k249_toggle_cycles", 32'(cyc_n), 32'd1536);
        check_init("k249_init", base);
        ksa_model(24'h000249);
        compare_ram("k249_final_s");
        run(24'h000249, 1'b0, cyc_n, base);
        check("k249_rerun_cycles", 32'(cyc_n), 32'd1536);
        check_init("k249_rerun_init", base);
        compare_ram("k249_rerun_final_s");

        // Reset 100 cycles into INIT
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        secret_key = 24'h123456;
        start = 1'b1;
        @(posedge clk);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("midinit_sWren_before", {31'd0, sWren}, 32'd1);
        reset = 1'b0;
        #1;
        check("midinit_sWren", {31'd0, sWren}, 32'd0);
        check("midinit_busy",  {31'd0, busy},  32'd0);
        check("midinit_sAddr", 32'(sAddr), 32'd0);
        check("midinit_done",  {31'd0, done},  32'd0);
        n0 = wa.size();
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_no_writes", 32'(wa.size() - n0), 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        run(24'h000249, 1'b0, cyc_n, base);
        check("post_rst_cycles", 32'(cyc_n), 32'd1536);
        compare_ram("post_rst_final_s");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
